// File: rtl/alu_trace_packer.sv
// alu_trace_packer: captures ALU transactions into a record FIFO and streams each record as four 32-bit words.
module alu_trace_packer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     trace_en,
  input  logic                     cap_valid,
  input  logic [WIDTH-1:0]         cap_src_a,
  input  logic [WIDTH-1:0]         cap_src_b,
  input  logic [3:0]               cap_alu_control,
  input  logic                     cap_is_branch,
  input  logic [2:0]               cap_branch_op,
  input  logic [WIDTH-1:0]         cap_alu_result,
  input  logic                     cap_branch_true,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [31:0]              out_data,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [15:0]              drop_count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, SEND} state_e;
  state_e state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [15:0] drop_q, drop_d;
  logic [7:0] seq_q, seq_d;
  logic [31:0] hdr_mem [DEPTH];
  logic [WIDTH-1:0] a_mem [DEPTH];
  logic [WIDTH-1:0] b_mem [DEPTH];
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic cap, full, xfer, pop, push;
  logic [31:0] word;
  always_comb begin
    cap = cap_valid & trace_en;
    out_valid = state_q == SEND;
    xfer = out_valid & out_ready;
    pop = xfer & (idx_q == 2'd3);
    full = cnt_q == (AW+1)'(DEPTH);
    // a full FIFO being popped this cycle still has room for the capture
    push = cap & (~full | pop);
    seq_d = cap ? seq_q + 8'd1 : seq_q;
    drop_d = (cap & full & ~pop & (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    wr_d = push ? wr_q + AW'(1) : wr_q;
    idx_d = xfer ? idx_q + 2'd1 : idx_q;
    // entering SEND on the push edge gives word0 in the very next cycle
    state_d = (cnt_d != '0) ? SEND : IDLE;
    word = idx_q == 2'd0 ? hdr_mem[rd_q] :
           idx_q == 2'd1 ? a_mem[rd_q] :
           idx_q == 2'd2 ? b_mem[rd_q] : r_mem[rd_q];
    out_data = out_valid ? word : 32'd0;
    out_last = out_valid & (idx_q == 2'd3);
    fifo_level = cnt_q;
    drop_count = drop_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      drop_q <= '0;
      seq_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      drop_q <= drop_d;
      seq_q <= seq_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      hdr_mem[wr_q] <= {8'hA5, cap_alu_control, cap_is_branch, cap_branch_op, cap_branch_true, 7'd0, seq_q};
      a_mem[wr_q] <= cap_src_a;
      b_mem[wr_q] <= cap_src_b;
      r_mem[wr_q] <= cap_alu_result;
    end
  end
endmodule

// File: tb/tb_alu_trace_packer.sv
// tb_alu_trace_packer: directed stimulus with a word scoreboard and a record-level FIFO model.
module tb_alu_trace_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trace_en = 1'b1;
  logic cap_valid = 1'b0;
  logic [31:0] cap_src_a = '0, cap_src_b = '0, cap_alu_result = '0;
  logic [3:0] cap_alu_control = '0;
  logic cap_is_branch = 1'b0;
  logic [2:0] cap_branch_op = '0;
  logic cap_branch_true = 1'b0;
  logic out_ready = 1'b0;
  logic out_valid, out_last;
  logic [31:0] out_data;
  logic [3:0] fifo_level;
  logic [15:0] drop_count;

  alu_trace_packer #(.WIDTH(32), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .trace_en(trace_en), .cap_valid(cap_valid),
    .cap_src_a(cap_src_a), .cap_src_b(cap_src_b), .cap_alu_control(cap_alu_control),
    .cap_is_branch(cap_is_branch), .cap_branch_op(cap_branch_op),
    .cap_alu_result(cap_alu_result), .cap_branch_true(cap_branch_true),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .fifo_level(fifo_level), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] d; logic l;} wd_t;
  wd_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int m_lvl = 0, m_idx = 0, m_drop = 0, m_seq = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ev);
    vectors++;
    assert (obs === ev) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, ev);
    end
  endtask

  task automatic push_rec();
    wd_t w;
    w.l = 1'b0;
    w.d = {8'hA5, cap_alu_control, cap_is_branch, cap_branch_op, cap_branch_true, 7'd0, 8'(m_seq)};
    exp_q.push_back(w);
    w.d = cap_src_a; exp_q.push_back(w);
    w.d = cap_src_b; exp_q.push_back(w);
    w.d = cap_alu_result; w.l = 1'b1; exp_q.push_back(w);
  endtask

  // checks current outputs, advances the model for this edge, then steps one clock
  task automatic cyc();
    logic xf, popm;
    chk("valid", 32'(out_valid), 32'(m_lvl != 0));
    chk("level", 32'(fifo_level), 32'(m_lvl));
    chk("drop", 32'(drop_count), 32'(m_drop));
    if (out_valid) begin
      chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        chk("data", out_data, exp_q[0].d);
        chk("last", 32'(out_last), 32'(exp_q[0].l));
      end
    end else chk("idle_last", 32'(out_last), 32'd0);
    xf = out_valid && out_ready;
    popm = xf && (m_idx == 3);
    if (xf && exp_q.size() != 0) void'(exp_q.pop_front());
    if (xf) m_idx = (m_idx + 1) % 4;
    if (cap_valid && trace_en) begin
      if (m_lvl < 8 || popm) begin
        push_rec();
        m_lvl++;
      end else if (m_drop < 65535) m_drop++;
      m_seq = (m_seq + 1) % 256;
    end
    if (popm) m_lvl--;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cap_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_lvl = 0; m_idx = 0; m_drop = 0; m_seq = 0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
  endtask

  task automatic set_cap(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         input logic br, input logic [2:0] bop, input logic [31:0] res, input logic bt);
    cap_src_a = a; cap_src_b = b; cap_alu_control = op; cap_is_branch = br;
    cap_branch_op = bop; cap_alu_result = res; cap_branch_true = bt; cap_valid = 1'b1;
  endtask

  task automatic set_rand();
    set_cap($urandom, $urandom, 4'($urandom), 1'($urandom), 3'($urandom), $urandom, 1'($urandom));
  endtask

  task automatic drain(input int budget);
    int n = 0;
    cap_valid = 1'b0;
    out_ready = 1'b1;
    while ((m_lvl != 0 || exp_q.size() != 0) && n < budget) begin
      cyc();
      n++;
    end
    chk("drain_done", 32'(m_lvl != 0 || exp_q.size() != 0), 32'd0);
    cyc();
  endtask

  initial begin
    do_reset();

    // single capture with the sink always ready
    out_ready = 1'b1;
    set_cap(32'h5, 32'h3, 4'h0, 1'b0, 3'h0, 32'h8, 1'b0);
    cyc();
    cap_valid = 1'b0;
    chk("single_hdr", out_data, 32'hA500_0000);
    for (int i = 0; i < 6; i++) cyc();
    chk("single_level", 32'(fifo_level), 32'd0);

    // six filler records bring seq to 7
    for (int i = 0; i < 6; i++) begin
      set_rand();
      cyc();
      cap_valid = 1'b0;
      for (int j = 0; j < 3; j++) cyc();
    end
    drain(40);

    // branch record under backpressure
    out_ready = 1'b0;
    set_cap(32'h1234_5678, 32'h1234_5678, 4'h1, 1'b1, 3'h1, 32'h0, 1'b1);
    cyc();
    cap_valid = 1'b0;
    chk("br_hdr", out_data, 32'hA519_8007);
    for (int i = 0; i < 20; i++) begin
      out_ready = (i % 4 == 0) || (i % 4 == 3);
      cyc();
    end
    chk("br_done", 32'(exp_q.size()), 32'd0);

    // overflow: ten captures into a stalled sink
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_rand();
      cyc();
    end
    cap_valid = 1'b0;
    chk("ovf_level", 32'(fifo_level), 32'd8);
    chk("ovf_drop", 32'(drop_count), 32'd2);
    drain(60);

    // full FIFO popped in the same cycle as a capture
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_rand();
      cyc();
    end
    cap_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    chk("pre_pop_last", 32'(out_last), 32'd1);
    set_rand();
    cyc();
    cap_valid = 1'b0;
    out_ready = 1'b0;
    chk("fullpop_level", 32'(fifo_level), 32'd8);
    chk("fullpop_drop", 32'(drop_count), 32'd2);
    cyc();
    drain(60);

    // reset in the middle of a record
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_rand();
      cyc();
    end
    cap_valid = 1'b0;
    out_ready = 1'b1;
    cyc();
    cyc();
    do_reset();
    set_rand();
    cyc();
    cap_valid = 1'b0;
    chk("post_rst_seq", 32'(out_data[7:0]), 32'd0);
    drain(20);

    // seq wrap and trace_en gating
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      set_rand();
      cyc();
      cap_valid = 1'b0;
      for (int j = 0; j < 3; j++) cyc();
    end
    drain(20);
    trace_en = 1'b0;
    set_rand();
    cyc();
    chk("gated_level", 32'(fifo_level), 32'd0);
    chk("gated_valid", 32'(out_valid), 32'd0);
    trace_en = 1'b1;
    set_rand();
    cyc();
    cap_valid = 1'b0;
    chk("wrap_seq", 32'(out_data[7:0]), 32'd0);
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_trace_packer.md
Name: alu_trace_packer

Overview:
Hardware-side producer of ALU transaction records, in the same 7-field vector format the ALU golden-model flow consumes: A, B, ALU op, is_branch, branch op, result, branch_true. It captures one ALU transaction per qualified cycle and buffers it in a small FIFO. Each record is serialized as a 4-word, 32-bit valid/ready stream for a trace sink (debug UART bridge or simulation dumper). It sits beside the core's ALU and observes its ports; it never drives the datapath.

Parameters:
WIDTH, 32, ALU operand/result width; must be 32 (records are word-aligned).
DEPTH, 8, FIFO depth in records; power of two, >= 2.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
trace_en  input  1  capture enable; when 0, captures are ignored entirely
cap_valid  input  1  ALU transaction present this cycle
cap_src_a  input  WIDTH  ALU operand A
cap_src_b  input  WIDTH  ALU operand B
cap_alu_control  input  4  alu_op_e encoding from lx32_pkg
cap_is_branch  input  1  branch compare active
cap_branch_op  input  3  branch_op_e encoding from branches_pkg
cap_alu_result  input  WIDTH  ALU result
cap_branch_true  input  1  ALU branch flag
out_ready  input  1  sink accepts word
out_valid  output  1  word available
out_data  output  32  record word
out_last  output  1  high on the final word (word 3) of a record
fifo_level  output  $clog2(DEPTH)+1  records currently buffered, including the one being serialized
drop_count  output  16  records lost to overflow; saturates at 16'hFFFF

Behaviour:
- Capture: capture event = cap_valid & trace_en on a rising edge of clk.
- Sequence number: 8-bit seq increments on every capture event, including dropped ones, and wraps 255->0. Gaps in the stream therefore expose drops.
- Record word layout:
  - Word0 (header): [31:24]=8'hA5, [23:20]=alu_control, [19]=is_branch, [18:16]=branch_op, [15]=branch_true, [14:8]=0, [7:0]=seq value at capture.
  - Word1 = A; Word2 = B; Word3 = result.
- FIFO push: a capture writes the record if the FIFO is not full. A FIFO that is full but is popped in the same cycle counts as not full, so the capture is accepted.
- Overflow: a capture into a full FIFO with no pop that cycle is dropped. drop_count += 1, saturating. Buffered contents are unchanged.
- Serializer state machine:
  - States: IDLE, then SEND with a 2-bit word index 0..3.
  - IDLE -> SEND(idx 0) when the FIFO is non-empty.
  - A word is transferred on out_valid & out_ready. On transfer, idx increments.
  - On the idx-3 transfer, the FIFO head is popped. The next state is SEND(idx 0) if more records remain, otherwise IDLE. There are no bubble cycles between back-to-back records.
- Latency: a record captured at edge N into an empty, idle block presents word0 with out_valid=1 in the cycle after edge N. With out_ready held at 1, word3 is transferred 3 cycles later.
- Stream rules:
  - out_valid, out_data and out_last must not change while out_valid=1 and out_ready=0.
  - out_valid never drops without a transfer.
  - out_last = out_valid & (idx==3).
- trace_en deasserted mid-record: the record in flight and all buffered records still drain. Only new captures stop.
- fifo_level: updates the cycle after a push or pop. Simultaneous push and pop leaves it unchanged.
- Reset (synchronous, any state, including mid-record): the FIFO empties and the state goes to IDLE. The following outputs are 0 from the first cycle after the reset edge: out_valid, out_last, out_data, fifo_level, drop_count, seq. Any partial record is discarded, not completed.

Test Plan:
- Single capture: A=32'h0000_0005, B=32'h0000_0003, op=4'h0, is_br=0, br_op=0, res=32'h0000_0008, br_true=0, out_ready=1. Required stream: 32'hA500_0000, 32'h5, 32'h3, 32'h8. out_last high only on the 4th word; fifo_level returns to 0.
- Branch record with backpressure: is_br=1, br_op=3'h1, br_true=1, op=4'h1, seq=7. out_ready toggles 1,0,0,1,… Required: header 32'hA519_8007. Each word is held stable through the stalls; 4 transfers in total; no duplicated or skipped words.
- Overflow: out_ready=0, 10 consecutive captures with DEPTH=8. Required: fifo_level=8, drop_count=2. Then raise out_ready: 8 records drain with seq 0..7; records with seq 8 and 9 are absent.
- Full plus simultaneous pop: FIFO holds 8 records, idx=3, out_ready=1, and a capture arrives in the same cycle. Required: capture accepted, drop_count unchanged, fifo_level stays 8.
- Reset mid-record: assert rst after word1 of a record is transferred, with 3 records buffered. Required: next cycle out_valid=0, fifo_level=0, drop_count=0. The first post-reset capture emits header seq=0.
- Seq wrap with trace_en gating: 256 captures drained, then one capture with trace_en=0, then one with trace_en=1. Required: the gated capture produces no record and no seq increment; the last record carries seq=0x00.
